load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent in WAIT before an error response.
REQ-002 clk  input  1  core clock; all state updates on the rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  MEM-stage access request.
REQ-005 req_ready  output  1  request accepted on the cycle (req_valid && req_ready).
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  64  byte address.
REQ-008 req_wdata  input  64  store data, right-aligned.
REQ-009 req_mem_op  input  3  000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 111 reserved.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_data  output  64  truncated and extended load data (the pipeline's mem_trunc); 0 for stores and errors.
REQ-012 resp_err  output  1  valid with resp_valid; access failed.
REQ-013 stall  output  1  pipeline hold.
REQ-014 mem_req_valid / mem_req_ready  output / input  1 / 1  memory request handshake.
REQ-015 mem_we  output  1;  mem_addr  output  64, 8-byte aligned;  mem_wdata  output  64, lane-shifted;  mem_wmask  output  8, byte enables.
REQ-016 mem_resp_valid  input  1;  mem_rdata  input  64  memory response and its doubleword.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, REQ, WAIT and RESP.
REQ-018 IDLE: req_ready=1; on accept, latch we/addr/wdata/op; go to REQ, or to RESP with error if REQ-026 applies.
REQ-019 REQ: mem_req_valid=1 with mem_* fields held stable; go to WAIT on mem_req_ready=1, otherwise stay in REQ.
REQ-020 WAIT: on mem_resp_valid=1, latch the processed result and go to RESP; each other cycle increments a counter; counter==TIMEOUT goes to RESP with resp_err=1.
REQ-021 RESP: resp_valid=1 for exactly one cycle, then IDLE; a new request is not accepted in RESP.
REQ-022 Minimum latency: resp_valid is asserted 3 cycles after the accept cycle when memory is ready and responds immediately.
REQ-023 stall SHALL be 1 in IDLE when req_valid=1, in REQ, and in WAIT; it SHALL be 0 in RESP and in an idle cycle with no request.
REQ-024 mem_addr = {addr[63:3],3'b000}; off = addr[2:0].
  - mem_wmask = (1,3,15,255 for B,H,W,D) << off, truncated to 8 bits.
  - mem_wdata = wdata << 8*off.
  - Loads drive mem_wmask=0.
REQ-025 Load result = mem_rdata >> 8*off, cut to size.
  - B/H/W: sign-extended.
  - BU/HU/WU: zero-extended.
  - D: unchanged.
REQ-026 An op of 111 SHALL go directly to RESP with resp_err=1 and SHALL NOT issue a memory request.
REQ-027 mem_resp_valid outside WAIT SHALL be ignored, including a late response after a timeout.
REQ-028 Stores also complete only on mem_resp_valid; their resp_data SHALL be 0.

Reset
REQ-029 Asserting rstn at any time, including mid-transaction, SHALL force IDLE immediately and abandon any outstanding memory access.
  - Cleared to 0: counter, latches, mem_req_valid, resp_valid, resp_err, resp_data.
REQ-030 req_ready SHALL read 1 and stall SHALL equal req_valid while in reset and after reset (state IDLE).

Configuration
REQ-031 Macro MISALIGN_TRAP_EN: when defined, an H, HU, W, WU or D access not naturally aligned SHALL go directly to RESP with resp_err=1 and SHALL NOT issue a memory request.
REQ-032 Without MISALIGN_TRAP_EN, the latched address SHALL first be aligned down to natural size (addr & ~(size-1)), and no misalignment error SHALL ever occur.

Verification
REQ-033 Load LB, addr 0x1003, mem_rdata 0x00000000_80000000, memory ready and responding immediately -> resp_valid 3 cycles after accept; resp_data 0xFFFFFFFFFFFFFF80; resp_err 0.
REQ-034 Store SH, addr 0x2006, wdata 0xABCD -> mem_addr 0x2000, mem_wmask 0xC0, mem_wdata 0xABCD000000000000; resp_data 0.
REQ-035 mem_req_ready held low 5 cycles, then LWU at 0x4, mem_rdata 0xF0000000_00000000 -> mem_* stable throughout REQ; resp_data 0x00000000F0000000; stall high until the RESP cycle.
REQ-036 TIMEOUT=4, no mem_resp_valid -> resp_err=1 4 cycles after entering WAIT; a later mem_resp_valid is ignored; the next request is accepted normally.
REQ-037 LD at 0x1004 -> with MISALIGN_TRAP_EN: resp_err=1 and mem_req_valid never asserted; without it: mem_addr 0x1000 and resp_err 0.
REQ-038 rstn pulsed low during WAIT -> resp_valid, mem_req_valid and stall drop immediately; the next request completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request/response and memory-side bus of the load/store unit.
interface load_store_unit_if;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_mem_op;
    logic        resp_valid, resp_err, stall;
    logic [63:0] resp_data;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_mem_op, mem_req_ready, mem_resp_valid, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_data, stall, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_mem_op, mem_req_ready, mem_resp_valid, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_data, stall, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding MEM-stage load/store FSM (IDLE/REQ/WAIT/RESP).
// Define MISALIGN_TRAP_EN to fault misaligned H/W/D accesses instead of aligning them down.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input logic             clk,
    input logic             rstn,
    load_store_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3;
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          we_q, err_q, err_in;
    logic [63:0]   addr_q, wdata_q, data_q, sh, res;
    logic [2:0]    op_q, off, amask;
    logic [1:0]    sz;
    logic [7:0]    base_mask;
    // op[1:0] encodes log2(size) for both signed and unsigned loads
    assign amask = ~(3'b111 << bus.req_mem_op[1:0]);
`ifdef MISALIGN_TRAP_EN
    assign err_in = (&bus.req_mem_op) || (|(bus.req_addr[2:0] & amask));
`else
    assign err_in = &bus.req_mem_op;
`endif
    assign sz = op_q[1:0];
    assign off = addr_q[2:0];
    assign base_mask = sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0f : 8'hff;
    assign sh = bus.mem_rdata >> {off, 3'b000};
    assign res = sz == 2'd3 ? sh :
                 sz == 2'd2 ? {{32{~op_q[2] & sh[31]}}, sh[31:0]} :
                 sz == 2'd1 ? {{48{~op_q[2] & sh[15]}}, sh[15:0]} :
                              {{56{~op_q[2] & sh[7]}}, sh[7:0]};
    assign bus.req_ready     = state == IDLE;
    assign bus.stall         = (state == IDLE && bus.req_valid) || state == REQ || state == WAIT;
    assign bus.resp_valid    = state == RESP;
    assign bus.resp_err      = state == RESP && err_q;
    assign bus.resp_data     = state == RESP ? data_q : 64'd0;
    assign bus.mem_req_valid = state == REQ;
    assign bus.mem_we        = we_q;
    assign bus.mem_addr      = {addr_q[63:3], 3'b000};
    assign bus.mem_wdata     = wdata_q << {off, 3'b000};
    assign bus.mem_wmask     = we_q ? base_mask << off : 8'h00;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            op_q    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    addr_q  <= {bus.req_addr[63:3], bus.req_addr[2:0] & ~amask};
                    wdata_q <= bus.req_wdata;
                    op_q    <= bus.req_mem_op;
                    data_q  <= '0;
                    err_q   <= err_in;
                    cnt     <= '0;
                    state   <= err_in ? RESP : REQ;
                end
                REQ: if (bus.mem_req_ready) state <= WAIT;
                WAIT: if (bus.mem_resp_valid) begin
                    data_q <= we_q ? 64'd0 : res;
                    state  <= RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    err_q <= 1'b1;
                    state <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized transactions against a byte-level reference model.
module tb_load_store_unit;
    localparam int TO = 4;
    logic clk = 1'b0, rstn = 1'b0;
    int checks = 0, failures = 0;
    load_store_unit_if bus();
    load_store_unit #(.TIMEOUT(TO)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;

    logic [63:0] o_data, o_addr, o_wdata;
    logic [7:0]  o_mask;
    logic        o_err, o_we, o_issued, o_stable, o_stall_ok, o_ready_ok;
    int          o_lat;

    function automatic int size_of(input logic [2:0] op);
        return 1 << op[1:0];
    endfunction
    function automatic int off_of(input logic [63:0] addr, input logic [2:0] op);
        int a = int'(addr[2:0]);
        return a - (a % size_of(op));
    endfunction
    function automatic logic req_err(input logic [63:0] addr, input logic [2:0] op);
        logic e = (op == 3'b111);
`ifdef MISALIGN_TRAP_EN
        if (int'(addr[2:0]) % size_of(op) != 0) e = 1'b1;
`endif
        return e;
    endfunction
    function automatic logic [63:0] exp_load(input logic [63:0] addr, rdata, input logic [2:0] op);
        int size = size_of(op);
        int off = off_of(addr, op);
        logic [63:0] v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!op[2] && size < 8 && v[8*size-1])
            for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction
    function automatic logic [7:0] exp_mask(input logic [63:0] addr, input logic [2:0] op);
        logic [7:0] m = '0;
        int off = off_of(addr, op);
        for (int i = 0; i < size_of(op); i++) m[off+i] = 1'b1;
        return m;
    endfunction

    task automatic run_txn(input logic we, input logic [63:0] addr, wdata, input logic [2:0] op,
                           input int rdy_dly, rsp_dly, input logic [63:0] rdata);
        int req_n = 0, wait_k = -1;
        bit hs = 0;
        o_lat = -1; o_issued = 0; o_stable = 1; o_stall_ok = 1;
        o_data = 'x; o_err = 'x; o_addr = 'x; o_wdata = 'x; o_mask = 'x; o_we = 'x;
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_mem_op = op;
        #1 o_ready_ok = (bus.req_ready === 1'b1) && (bus.stall === 1'b1);
        @(negedge clk);
        bus.req_valid = 0;
        #1;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) begin @(negedge clk); #1; end
            if (bus.resp_valid === 1'b1) begin
                o_lat = c; o_data = bus.resp_data; o_err = bus.resp_err;
                if (bus.stall !== 1'b0) o_stall_ok = 0;
                break;
            end
            if (bus.stall !== 1'b1) o_stall_ok = 0;
            bus.mem_resp_valid = 0;
            bus.mem_rdata = rdata;
            if (hs) begin
                wait_k++;
                bus.mem_resp_valid = (wait_k == rsp_dly);
            end
            if (bus.mem_req_valid === 1'b1) begin
                if (!o_issued) begin
                    o_addr = bus.mem_addr; o_wdata = bus.mem_wdata; o_mask = bus.mem_wmask; o_we = bus.mem_we;
                end else if (bus.mem_addr !== o_addr || bus.mem_wdata !== o_wdata ||
                             bus.mem_wmask !== o_mask || bus.mem_we !== o_we) o_stable = 0;
                o_issued = 1;
                req_n++;
                bus.mem_req_ready = (req_n > rdy_dly);
                if (bus.mem_req_ready) hs = 1;
            end else bus.mem_req_ready = 0;
        end
        bus.mem_resp_valid = 0;
        bus.mem_req_ready = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_stall0 got=%b exp=0", bus.stall); end
        checks++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_data !== 64'd0)
            begin failures++; $display("FAIL rst_resp got=%b/%b/%h exp=0/0/0", bus.resp_valid, bus.resp_err, bus.resp_data); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_memreq got=%b exp=0", bus.mem_req_valid); end
        bus.req_valid = 1; #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL rst_stall1 got=%b exp=1", bus.stall); end
        bus.req_valid = 0;
        repeat (2) @(negedge clk);
        rstn = 1;
        #1;
        checks++; if (bus.req_ready !== 1'b1 || bus.stall !== 1'b0)
            begin failures++; $display("FAIL post_rst got=%b/%b exp=1/0", bus.req_ready, bus.stall); end
    endtask

    task automatic test_load_byte();
        run_txn(1'b0, 64'h1003, 64'd0, 3'b000, 0, 0, 64'h00000000_80000000);
        checks++; if (o_lat !== 3) begin failures++; $display("FAIL lb_latency got=%0d exp=3", o_lat); end
        checks++; if (o_data !== 64'hFFFFFFFFFFFFFF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffffffffffff80", o_data); end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL lb_err got=%b exp=0", o_err); end
        checks++; if (o_mask !== 8'h00 || o_addr !== 64'h1000) begin failures++; $display("FAIL lb_mem got=%h/%h exp=1000/00", o_addr, o_mask); end
    endtask

    task automatic test_store_half();
        run_txn(1'b1, 64'h2006, 64'hABCD, 3'b001, 0, 0, 64'hDEAD_BEEF_0000_1111);
        checks++; if (o_addr !== 64'h2000) begin failures++; $display("FAIL sh_addr got=%h exp=2000", o_addr); end
        checks++; if (o_mask !== 8'hC0) begin failures++; $display("FAIL sh_mask got=%h exp=c0", o_mask); end
        checks++; if (o_wdata !== 64'hABCD000000000000) begin failures++; $display("FAIL sh_wdata got=%h exp=abcd000000000000", o_wdata); end
        checks++; if (o_data !== 64'd0 || o_err !== 1'b0 || o_we !== 1'b1)
            begin failures++; $display("FAIL sh_resp got=%h/%b/%b exp=0/0/1", o_data, o_err, o_we); end
    endtask

    task automatic test_ready_backpressure();
        run_txn(1'b0, 64'h4, 64'd0, 3'b110, 5, 0, 64'hF0000000_00000000);
        checks++; if (o_stable !== 1'b1) begin failures++; $display("FAIL bp_stable got=%b exp=1", o_stable); end
        checks++; if (o_data !== 64'h00000000F0000000) begin failures++; $display("FAIL bp_data got=%h exp=00000000f0000000", o_data); end
        checks++; if (o_stall_ok !== 1'b1 || o_ready_ok !== 1'b1) begin failures++; $display("FAIL bp_stall got=%b/%b exp=1/1", o_stall_ok, o_ready_ok); end
        checks++; if (o_lat !== 8) begin failures++; $display("FAIL bp_latency got=%0d exp=8", o_lat); end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 64'h10, 64'd0, 3'b011, 0, -1, 64'h1234);
        checks++; if (o_lat !== 2 + TO) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", o_lat, 2 + TO); end
        checks++; if (o_err !== 1'b1 || o_data !== 64'd0) begin failures++; $display("FAIL to_err got=%b/%h exp=1/0", o_err, o_data); end
        @(negedge clk);
        bus.mem_resp_valid = 1; bus.mem_rdata = 64'hFFFF;
        @(negedge clk); #1;
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1)
            begin failures++; $display("FAIL to_late got=%b/%b exp=0/1", bus.resp_valid, bus.req_ready); end
        bus.mem_resp_valid = 0;
        run_txn(1'b0, 64'h20, 64'd0, 3'b010, 0, 1, 64'h0000_0000_7FFF_FFFF);
        checks++; if (o_lat !== 4 || o_err !== 1'b0 || o_data !== 64'h7FFFFFFF)
            begin failures++; $display("FAIL to_next got=%0d/%b/%h exp=4/0/7fffffff", o_lat, o_err, o_data); end
    endtask

    task automatic test_misalign();
        run_txn(1'b0, 64'h1004, 64'd0, 3'b011, 0, 0, 64'h0123_4567_89AB_CDEF);
`ifdef MISALIGN_TRAP_EN
        checks++; if (o_err !== 1'b1 || o_issued !== 1'b0 || o_lat !== 1)
            begin failures++; $display("FAIL mis_trap got=%b/%b/%0d exp=1/0/1", o_err, o_issued, o_lat); end
`else
        checks++; if (o_addr !== 64'h1000 || o_err !== 1'b0 || o_data !== 64'h0123456789ABCDEF)
            begin failures++; $display("FAIL mis_align got=%h/%b/%h exp=1000/0/0123456789abcdef", o_addr, o_err, o_data); end
`endif
    endtask

    task automatic test_reserved_op();
        run_txn(1'b0, 64'h3000, 64'd0, 3'b111, 0, 0, 64'h55);
        checks++; if (o_err !== 1'b1 || o_issued !== 1'b0 || o_lat !== 1 || o_data !== 64'd0)
            begin failures++; $display("FAIL rsv got=%b/%b/%0d/%h exp=1/0/1/0", o_err, o_issued, o_lat, o_data); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 64'h5000; bus.req_mem_op = 3'b011;
        @(negedge clk);
        bus.req_valid = 0; bus.mem_req_ready = 1;
        @(negedge clk);
        bus.mem_req_ready = 0;
        #1;
        checks++; if (bus.stall !== 1'b1 || bus.mem_req_valid !== 1'b0)
            begin failures++; $display("FAIL mid_inwait got=%b/%b exp=1/0", bus.stall, bus.mem_req_valid); end
        rstn = 0;
        #1;
        checks++; if (bus.stall !== 1'b0 || bus.resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.req_ready !== 1'b1)
            begin failures++; $display("FAIL mid_rst got=%b/%b/%b/%b exp=0/0/0/1", bus.stall, bus.resp_valid, bus.mem_req_valid, bus.req_ready); end
        @(negedge clk);
        rstn = 1;
        bus.mem_resp_valid = 1; bus.mem_rdata = 64'h77;
        @(negedge clk); #1;
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL mid_stale got=%b exp=0", bus.resp_valid); end
        bus.mem_resp_valid = 0;
        run_txn(1'b0, 64'h5001, 64'd0, 3'b100, 0, 0, 64'h0000_0000_0000_9900);
        checks++; if (o_lat !== 3 || o_err !== 1'b0 || o_data !== 64'h99)
            begin failures++; $display("FAIL mid_next got=%0d/%b/%h exp=3/0/99", o_lat, o_err, o_data); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic we = 1'($urandom);
            logic [63:0] addr = {$urandom, $urandom};
            logic [63:0] wd = {$urandom, $urandom};
            logic [63:0] rd = {$urandom, $urandom};
            logic [2:0] op = 3'($urandom_range(0, 7));
            int rdy = $urandom_range(0, 3);
            int rsp = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
            logic e = req_err(addr, op);
            logic tmo = !e && (rsp < 0 || rsp >= TO);
            int lat = e ? 1 : 2 + rdy + (tmo ? TO : rsp + 1);
            logic [63:0] d = (e || tmo || we) ? 64'd0 : exp_load(addr, rd, op);
            run_txn(we, addr, wd, op, rdy, rsp, rd);
            checks++; if (o_lat !== lat || o_err !== (e | tmo))
                begin failures++; $display("FAIL rnd%0d_lat_err got=%0d/%b exp=%0d/%b", n, o_lat, o_err, lat, e | tmo); end
            checks++; if (o_data !== d) begin failures++; $display("FAIL rnd%0d_data got=%h exp=%h", n, o_data, d); end
            checks++; if (o_issued !== !e || o_stall_ok !== 1'b1 || o_ready_ok !== 1'b1)
                begin failures++; $display("FAIL rnd%0d_ctl got=%b/%b/%b exp=%b/1/1", n, o_issued, o_stall_ok, o_ready_ok, !e); end
            if (!e) begin
                logic [63:0] ew = wd << (8 * off_of(addr, op));
                logic [7:0] em = we ? exp_mask(addr, op) : 8'h00;
                checks++; if (o_addr !== {addr[63:3], 3'b000} || o_mask !== em || o_wdata !== ew || o_we !== we || o_stable !== 1'b1)
                    begin failures++; $display("FAIL rnd%0d_mem got=%h/%h/%h/%b/%b exp=%h/%h/%h/%b/1", n, o_addr, o_mask, o_wdata, o_we, o_stable,
                                                {addr[63:3], 3'b000}, em, ew, we); end
            end
        end
    endtask

    initial begin
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_mem_op = '0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0;
        test_reset();
        test_load_byte();
        test_store_half();
        test_ready_backpressure();
        test_timeout();
        test_misalign();
        test_reserved_op();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
